// File: rtl/app_spi_slave_if.sv
// rtl/app_spi_slave_if.sv - SPI pins and register-bus bundle for app_spi_slave
interface app_spi_slave_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7
);
  logic                  APP_FPGA_SPI_CLK;
  logic                  APP_FPGA_SPI_CS_N;
  logic                  APP_FPGA_SPI_MOSI;
  logic                  APP_FPGA_SPI_MISO;
  logic                  APP_FPGA_SPI_MISO_OE;
  logic [ADDR_WIDTH-1:0] REG_ADDR;
  logic [DATA_WIDTH-1:0] REG_WDATA;
  logic                  REG_WR_STB;
  logic                  REG_RD_STB;
  logic [DATA_WIDTH-1:0] REG_RDATA;
  logic                  FRAME_BUSY;
  logic [7:0]            ERR_CNT;

  modport slave (
    input  APP_FPGA_SPI_CLK, APP_FPGA_SPI_CS_N, APP_FPGA_SPI_MOSI, REG_RDATA,
    output APP_FPGA_SPI_MISO, APP_FPGA_SPI_MISO_OE, REG_ADDR, REG_WDATA,
           REG_WR_STB, REG_RD_STB, FRAME_BUSY, ERR_CNT
  );

  modport master (
    output APP_FPGA_SPI_CLK, APP_FPGA_SPI_CS_N, APP_FPGA_SPI_MOSI, REG_RDATA,
    input  APP_FPGA_SPI_MISO, APP_FPGA_SPI_MISO_OE, REG_ADDR, REG_WDATA,
           REG_WR_STB, REG_RD_STB, FRAME_BUSY, ERR_CNT
  );
endinterface

// File: rtl/app_spi_slave.sv
// rtl/app_spi_slave.sv - SPI mode-0 slave bridging frames onto a register bus
// Optional abort counter enabled by defining APP_SPI_ERR_CNT_EN.
module app_spi_slave #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7
) (
  input  logic           OPB_CLK,
  input  logic           OPB_RST_N,
  app_spi_slave_if.slave bus
);

  localparam int CMD_BITS = ADDR_WIDTH + 1;
  localparam int MAX_BITS = (CMD_BITS > DATA_WIDTH) ? CMD_BITS : DATA_WIDTH;
  localparam int CNT_W    = $clog2(MAX_BITS) + 1;

  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_CS} state_t;

  state_t state, state_nxt;

  logic [1:0] sck_sync, cs_sync, mosi_sync;
  logic       sck_prev;
  logic [1:0] settle;
  logic       armed;

  logic                  sck, cs_n, mosi;
  logic                  sck_rise, sck_fall;
  logic [CNT_W-1:0]      bit_cnt;
  logic [ADDR_WIDTH-1:0] cmd_sr;
  logic [DATA_WIDTH-2:0] data_sr;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [CMD_BITS-1:0]   cmd_word;
  logic [DATA_WIDTH-1:0] data_word;
  logic                  is_read;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic                  wr_stb, rd_stb;
  logic [1:0]            rd_pipe;
  logic                  cmd_done, data_done, abort;
  logic                  miso, busy;

  // settle/armed keep a frame already in progress at reset release from being accepted
  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST_N) begin
      sck_sync  <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_prev  <= 1'b0;
      settle    <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], bus.APP_FPGA_SPI_CLK};
      cs_sync   <= {cs_sync[0], bus.APP_FPGA_SPI_CS_N};
      mosi_sync <= {mosi_sync[0], bus.APP_FPGA_SPI_MOSI};
      sck_prev  <= sck_sync[1];
      settle    <= {settle[0], 1'b1};
      if (settle[1] && cs_sync[1]) armed <= 1'b1;
    end
  end

  assign sck       = sck_sync[1];
  assign cs_n      = cs_sync[1];
  assign mosi      = mosi_sync[1];
  assign sck_rise  = sck & ~sck_prev;
  assign sck_fall  = ~sck & sck_prev;
  assign cmd_word  = {cmd_sr, mosi};
  assign data_word = {data_sr, mosi};

  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST_N) state <= IDLE;
    else            state <= state_nxt;
  end

  // A CS_N rise landing on the final data rise still completes the frame
  always_comb begin
    state_nxt = state;
    cmd_done  = 1'b0;
    data_done = 1'b0;
    abort     = 1'b0;
    miso      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (armed && !cs_n) state_nxt = CMD;
      end
      CMD: begin
        cmd_done = sck_rise && !cs_n && (bit_cnt == CNT_W'(CMD_BITS - 1));
        abort    = cs_n;
        if (abort)         state_nxt = IDLE;
        else if (cmd_done) state_nxt = DATA;
      end
      DATA: begin
        data_done = sck_rise && (bit_cnt == CNT_W'(DATA_WIDTH - 1));
        abort     = cs_n && !data_done;
        miso      = is_read & tx_sr[DATA_WIDTH-1];
        if (data_done)  state_nxt = WAIT_CS;
        else if (abort) state_nxt = IDLE;
      end
      WAIT_CS: begin
        if (cs_n) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST_N) begin
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      data_sr   <= '0;
      tx_sr     <= '0;
      is_read   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      wr_stb    <= 1'b0;
      rd_stb    <= 1'b0;
      rd_pipe   <= 2'b00;
    end else begin
      wr_stb  <= 1'b0;
      rd_stb  <= 1'b0;
      rd_pipe <= {rd_pipe[0], rd_stb};
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          tx_sr   <= '0;
          is_read <= 1'b0;
        end
        CMD: begin
          if (sck_rise) begin
            cmd_sr  <= cmd_word[ADDR_WIDTH-1:0];
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (cmd_done) begin
            bit_cnt  <= '0;
            reg_addr <= cmd_word[ADDR_WIDTH-1:0];
            is_read  <= cmd_word[ADDR_WIDTH];
            rd_stb   <= cmd_word[ADDR_WIDTH];
          end
        end
        DATA: begin
          if (sck_rise) begin
            data_sr <= data_word[DATA_WIDTH-2:0];
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (data_done && !is_read) begin
            reg_wdata <= data_word;
            wr_stb    <= 1'b1;
          end
          // The fall right after the command only presents the MSB, so shifting starts after data bit 0
          if (rd_pipe[1])
            tx_sr <= bus.REG_RDATA;
          else if (sck_fall && bit_cnt != '0)
            tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
        end
        default: ;
      endcase
    end
  end

`ifdef APP_SPI_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST_N)                  err_cnt <= 8'h00;
    else if (abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
  end

  assign bus.ERR_CNT = err_cnt;
`else
  assign bus.ERR_CNT = 8'h00;
`endif

  assign bus.APP_FPGA_SPI_MISO    = miso;
  assign bus.APP_FPGA_SPI_MISO_OE = ~cs_n;
  assign bus.REG_ADDR             = reg_addr;
  assign bus.REG_WDATA            = reg_wdata;
  assign bus.REG_WR_STB           = wr_stb;
  assign bus.REG_RD_STB           = rd_stb;
  assign bus.FRAME_BUSY           = busy;

endmodule

// File: tb/tb_app_spi_slave.sv
// tb/tb_app_spi_slave.sv - randomized SPI master driving app_spi_slave against a frame-level model
module tb_app_spi_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  app_spi_slave_if #(.DATA_WIDTH(16), .ADDR_WIDTH(7)) bus ();

  app_spi_slave #(.DATA_WIDTH(16), .ADDR_WIDTH(7)) dut (
    .OPB_CLK   (clk),
    .OPB_RST_N (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] periph [128] = '{default: 16'h0000};
  logic [15:0] model  [128] = '{default: 16'h0000};

  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          miso_bad = 0;
  bit          miso_watch = 1'b0;
  logic [6:0]  last_waddr = '0;
  logic [15:0] last_wdata = '0;
  logic [6:0]  last_raddr = '0;

  int          half = 40;
  int          bit_idx = -1;
  int          abort_n = 0;
  logic [15:0] exp_wdata = '0;
  logic [15:0] miso_word;

  assign bus.REG_RDATA = periph[bus.REG_ADDR];

  // Peripheral side: a register file written by the strobes, plus strobe counters
  always @(negedge clk) begin
    if (bus.REG_WR_STB) begin
      wr_cnt++;
      last_waddr = bus.REG_ADDR;
      last_wdata = bus.REG_WDATA;
      periph[bus.REG_ADDR] = bus.REG_WDATA;
    end
    if (bus.REG_RD_STB) begin
      rd_cnt++;
      last_raddr = bus.REG_ADDR;
    end
    if (miso_watch && bus.APP_FPGA_SPI_MISO) miso_bad++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_err();
`ifdef APP_SPI_ERR_CNT_EN
    return (abort_n > 255) ? 8'hFF : 8'(abort_n);
`else
    return 8'h00;
`endif
  endfunction

  task automatic spi_xfer(input logic [7:0] cmd, input logic [15:0] data, input int nclk,
                          input bit end_cs, input bit cs_on_last);
    miso_word = '0;
    @(negedge clk);
    #2;
    bus.APP_FPGA_SPI_CS_N = 1'b0;
    #(half);
    for (int i = 0; i < nclk; i++) begin
      bit_idx = i;
      if (i < 8)       bus.APP_FPGA_SPI_MOSI = cmd[7-i];
      else if (i < 24) bus.APP_FPGA_SPI_MOSI = data[23-i];
      else             bus.APP_FPGA_SPI_MOSI = 1'($urandom_range(0, 1));
      #(half);
      if (cs_on_last && i == nclk - 1) bus.APP_FPGA_SPI_CS_N = 1'b1;
      bus.APP_FPGA_SPI_CLK = 1'b1;
      if (i >= 8 && i < 24) miso_word[23-i] = bus.APP_FPGA_SPI_MISO;
      #(half);
      bus.APP_FPGA_SPI_CLK = 1'b0;
    end
    bit_idx = nclk;
    if (end_cs) begin
      #(half);
      bus.APP_FPGA_SPI_CS_N = 1'b1;
    end
    #(2 * half + 40);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++; if (bus.REG_ADDR !== 7'h00) begin n_err++; $display("FAIL reset_addr got %h want 00", bus.REG_ADDR); end
    n_vec++; if (bus.REG_WDATA !== 16'h0000) begin n_err++; $display("FAIL reset_wdata got %h want 0000", bus.REG_WDATA); end
    n_vec++; if ({bus.REG_WR_STB, bus.REG_RD_STB} !== 2'b00) begin n_err++; $display("FAIL reset_strobes got %b want 00", {bus.REG_WR_STB, bus.REG_RD_STB}); end
    n_vec++; if ({bus.APP_FPGA_SPI_MISO, bus.APP_FPGA_SPI_MISO_OE} !== 2'b00) begin n_err++; $display("FAIL reset_miso got %b want 00", {bus.APP_FPGA_SPI_MISO, bus.APP_FPGA_SPI_MISO_OE}); end
    n_vec++; if (bus.FRAME_BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.FRAME_BUSY); end
    n_vec++; if (bus.ERR_CNT !== 8'h00) begin n_err++; $display("FAIL reset_err got %h want 00", bus.ERR_CNT); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    int w0 = wr_cnt, r0 = rd_cnt, m0 = miso_bad;
    miso_watch = 1'b1;
    spi_xfer(8'h05, 16'hA5C3, 24, 1'b1, 1'b0);
    miso_watch = 1'b0;
    model[5] = 16'hA5C3; exp_wdata = 16'hA5C3;
    n_vec++; if (wr_cnt - w0 != 1 || rd_cnt != r0) begin n_err++; $display("FAIL write_strobes got wr=%0d rd=%0d want wr=1 rd=0", wr_cnt - w0, rd_cnt - r0); end
    n_vec++; if (last_waddr !== 7'h05) begin n_err++; $display("FAIL write_addr got %h want 05", last_waddr); end
    n_vec++; if (bus.REG_WDATA !== 16'hA5C3) begin n_err++; $display("FAIL write_wdata got %h want a5c3", bus.REG_WDATA); end
    n_vec++; if (miso_bad != m0) begin n_err++; $display("FAIL write_miso_quiet got %0d high samples want 0", miso_bad - m0); end
    n_vec++; if (bus.FRAME_BUSY !== 1'b0) begin n_err++; $display("FAIL write_busy_end got %b want 0", bus.FRAME_BUSY); end
  endtask

  task automatic test_read();
    int w0, r0;
    spi_xfer(8'h03, 16'h1234, 24, 1'b1, 1'b0);
    model[3] = 16'h1234; exp_wdata = 16'h1234;
    w0 = wr_cnt; r0 = rd_cnt;
    spi_xfer(8'h83, 16'h0000, 24, 1'b1, 1'b0);
    n_vec++; if (rd_cnt - r0 != 1 || wr_cnt != w0) begin n_err++; $display("FAIL read_strobes got rd=%0d wr=%0d want rd=1 wr=0", rd_cnt - r0, wr_cnt - w0); end
    n_vec++; if (last_raddr !== 7'h03) begin n_err++; $display("FAIL read_addr got %h want 03", last_raddr); end
    n_vec++; if (miso_word !== model[3]) begin n_err++; $display("FAIL read_miso got %h want %h", miso_word, model[3]); end
  endtask

  task automatic test_abort();
    int w0 = wr_cnt, r0 = rd_cnt;
    spi_xfer(8'h02, 16'($urandom), 12, 1'b1, 1'b0);
    abort_n++;
    n_vec++; if (wr_cnt != w0 || rd_cnt != r0) begin n_err++; $display("FAIL abort_strobes got wr=%0d rd=%0d want 0", wr_cnt - w0, rd_cnt - r0); end
    n_vec++; if (bus.REG_WDATA !== exp_wdata) begin n_err++; $display("FAIL abort_wdata got %h want %h", bus.REG_WDATA, exp_wdata); end
    n_vec++; if (bus.ERR_CNT !== exp_err()) begin n_err++; $display("FAIL abort_errcnt got %h want %h", bus.ERR_CNT, exp_err()); end
    n_vec++; if (bus.FRAME_BUSY !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", bus.FRAME_BUSY); end
  endtask

  task automatic test_coincident();
    int w0 = wr_cnt;
    spi_xfer(8'h11, 16'h5A3C, 24, 1'b0, 1'b1);
    model[7'h11] = 16'h5A3C; exp_wdata = 16'h5A3C;
    n_vec++; if (wr_cnt - w0 != 1) begin n_err++; $display("FAIL coincident_strobe got %0d want 1", wr_cnt - w0); end
    n_vec++; if (bus.REG_WDATA !== 16'h5A3C) begin n_err++; $display("FAIL coincident_wdata got %h want 5a3c", bus.REG_WDATA); end
    n_vec++; if (bus.ERR_CNT !== exp_err()) begin n_err++; $display("FAIL coincident_errcnt got %h want %h", bus.ERR_CNT, exp_err()); end
  endtask

  task automatic test_overrun();
    int w0 = wr_cnt;
    logic [15:0] d = 16'($urandom);
    spi_xfer(8'h22, d, 30, 1'b0, 1'b0);
    model[7'h22] = d; exp_wdata = d;
    n_vec++; if (wr_cnt - w0 != 1) begin n_err++; $display("FAIL overrun_strobe got %0d want 1", wr_cnt - w0); end
    n_vec++; if ({bus.FRAME_BUSY, bus.APP_FPGA_SPI_MISO_OE} !== 2'b11) begin n_err++; $display("FAIL overrun_waitcs got %b want 11", {bus.FRAME_BUSY, bus.APP_FPGA_SPI_MISO_OE}); end
    bus.APP_FPGA_SPI_CS_N = 1'b1;
    repeat (6) @(negedge clk);
    n_vec++; if (bus.FRAME_BUSY !== 1'b0) begin n_err++; $display("FAIL overrun_release got %b want 0", bus.FRAME_BUSY); end
    n_vec++; if (wr_cnt - w0 != 1 || bus.REG_WDATA !== d) begin n_err++; $display("FAIL overrun_wdata got %h/%0d want %h/1", bus.REG_WDATA, wr_cnt - w0, d); end
  endtask

  task automatic test_reset_midframe();
    int w0 = wr_cnt;
    bit_idx = -1;
    fork
      spi_xfer(8'h07, 16'hBEEF, 24, 1'b1, 1'b0);
      begin
        wait (bit_idx == 20);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.REG_ADDR, bus.REG_WDATA, bus.REG_WR_STB, bus.REG_RD_STB, bus.APP_FPGA_SPI_MISO,
             bus.APP_FPGA_SPI_MISO_OE, bus.FRAME_BUSY, bus.ERR_CNT} !== '0) begin
          n_err++; $display("FAIL midreset_outputs got addr=%h wdata=%h oe=%b busy=%b err=%h want all 0",
                            bus.REG_ADDR, bus.REG_WDATA, bus.APP_FPGA_SPI_MISO_OE, bus.FRAME_BUSY, bus.ERR_CNT);
        end
        wait (bit_idx == 22);
        rst_n = 1'b1;
      end
    join
    abort_n = 0; exp_wdata = 16'h0000;
    n_vec++; if (wr_cnt != w0 || bus.REG_WDATA !== 16'h0000) begin n_err++; $display("FAIL midreset_discard got wr=%0d wdata=%h want 0/0000", wr_cnt - w0, bus.REG_WDATA); end
    spi_xfer(8'h01, 16'h00FF, 24, 1'b1, 1'b0);
    model[1] = 16'h00FF; exp_wdata = 16'h00FF;
    n_vec++; if (wr_cnt - w0 != 1 || last_waddr !== 7'h01 || bus.REG_WDATA !== 16'h00FF) begin
      n_err++; $display("FAIL midreset_recover got wr=%0d addr=%h wdata=%h want 1/01/00ff", wr_cnt - w0, last_waddr, bus.REG_WDATA);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      int w0 = wr_cnt, r0 = rd_cnt;
      bit rw = 1'($urandom_range(0, 1));
      logic [6:0]  a = 7'($urandom_range(0, 127));
      logic [15:0] d = 16'($urandom);
      half = 10 * $urandom_range(4, 7);
      spi_xfer({rw, a}, d, 24, 1'b1, 1'b0);
      if (rw) begin
        n_vec++; if (rd_cnt - r0 != 1 || wr_cnt != w0 || last_raddr !== a || miso_word !== model[a]) begin
          n_err++; $display("FAIL rand_read[%0d] addr=%h got %h rd=%0d want %h rd=1", n, a, miso_word, rd_cnt - r0, model[a]);
        end
      end else begin
        model[a] = d; exp_wdata = d;
        n_vec++; if (wr_cnt - w0 != 1 || rd_cnt != r0 || last_waddr !== a || last_wdata !== d) begin
          n_err++; $display("FAIL rand_write[%0d] got addr=%h data=%h wr=%0d want addr=%h data=%h wr=1", n, last_waddr, last_wdata, wr_cnt - w0, a, d);
        end
      end
    end
    half = 40;
  endtask

  task automatic test_saturation();
    int w0 = wr_cnt, r0 = rd_cnt;
    for (int n = 0; n < 260; n++) begin
      spi_xfer(8'($urandom), 16'h0000, 3, 1'b1, 1'b0);
      abort_n++;
      if (n == 254) begin
        n_vec++; if (bus.ERR_CNT !== exp_err()) begin n_err++; $display("FAIL sat_255 got %h want %h", bus.ERR_CNT, exp_err()); end
      end
    end
    n_vec++; if (bus.ERR_CNT !== exp_err()) begin n_err++; $display("FAIL sat_260 got %h want %h", bus.ERR_CNT, exp_err()); end
    n_vec++; if (wr_cnt != w0 || rd_cnt != r0) begin n_err++; $display("FAIL sat_strobes got wr=%0d rd=%0d want 0", wr_cnt - w0, rd_cnt - r0); end
  endtask

  initial begin
    bus.APP_FPGA_SPI_CLK  = 1'b0;
    bus.APP_FPGA_SPI_CS_N = 1'b1;
    bus.APP_FPGA_SPI_MOSI = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_coincident();
    test_overrun();
    test_reset_midframe();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
